// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: register bus, stage indices, FSM states.
// Purely declarative; no logic or latency.
// No flow control; the constants are used by pipeline_ctrl and its consumers.
package pipeline_ctrl_pkg;

  // One bit per pipeline register, PC at bit 0 through MEM/WB at bit 4
  localparam int STALL_W = 5;
  typedef logic [STALL_W-1:0] stall_bus_t;

  // Pipeline register indices within a stall/flush bus
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;

  // Flush pattern for an exception: everything past the PC becomes a NOP
  localparam stall_bus_t EXC_FLUSH = 5'b11110;
  // Flush pattern while reset is held: every register clears
  localparam stall_bus_t RST_FLUSH = 5'b11111;

  // Exception sequencer states
  typedef enum logic {
    PCTL_IDLE = 1'b0,
    PCTL_EXCP = 1'b1
  } pctl_state_e;

  // Hold mask for a stall raised at stage index top_stg (IF=0 .. MEM=3):
  // the requesting stage's register and every register upstream of it.
  function automatic stall_bus_t hold_mask(input logic [1:0] top_stg);
    stall_bus_t m;
    case (top_stg)
      2'd0:    m = 5'b00001;
      2'd1:    m = 5'b00011;
      2'd2:    m = 5'b00111;
      default: m = 5'b01111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Merges stage stall requests into per-register stall/flush and sequences exception redirects.
// Outputs are combinational from inputs and state (0 cycles); redirect waits for the fetch to finish.
// A stalled stage freezes itself and everything upstream; a bubble is injected just downstream.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic             id_req,
  input  logic             ex_req,
  input  logic             mem_req,
  input  logic             exc_req,
  input  logic [31:0]      exc_pc,
  input  logic             perf_clr,
  output logic [4:0]       stall,
  output logic [4:0]       flush,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             exc_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  pctl_state_e      state_q, state_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_req;
  logic [1:0]       top_stg;

  // Find the most downstream stage asking for a stall
  always_comb begin
    any_req = if_req | id_req | ex_req | mem_req;
    top_stg = 2'd0;
    if (mem_req) begin
      top_stg = 2'd3;
    end else if (ex_req) begin
      top_stg = 2'd2;
    end else if (id_req) begin
      top_stg = 2'd1;
    end
  end

  // Exception sequencer next state and the stall/flush/redirect outputs
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    stall       = '0;
    flush       = '0;
    pc_redirect = 1'b0;
    exc_busy    = 1'b0;
    redirect_pc = (state_q == PCTL_EXCP) ? tgt_q : exc_pc;
    if (rst) begin
      // Flops are clearing anyway; keep the pipeline empty while reset is held
      flush = RST_FLUSH;
    end else begin
      case (state_q)
        PCTL_IDLE: begin
          if (exc_req) begin
            // Exception outranks every stage stall request
            flush = EXC_FLUSH;
            if (if_req) begin
              // A fetch is in flight; park the target until the bus goes quiet
              stall[STG_PC] = 1'b1;
              tgt_d         = exc_pc;
              state_d       = PCTL_EXCP;
            end else begin
              pc_redirect = 1'b1;
            end
          end else if (any_req) begin
            stall = hold_mask(top_stg);
            flush = hold_mask(top_stg) + 5'd1;
          end
        end
        PCTL_EXCP: begin
          // Further exceptions are ignored: the first target is delivered
          flush    = EXC_FLUSH;
          exc_busy = 1'b1;
          if (if_req) begin
            stall[STG_PC] = 1'b1;
          end else begin
            pc_redirect = 1'b1;
            state_d     = PCTL_IDLE;
          end
        end
        default: begin
          state_d = PCTL_IDLE;
        end
      endcase
    end
  end

  // Saturating count of cycles where the PC is held; clear beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (perf_clr) begin
      cnt_d = '0;
    end else if (stall[STG_PC] && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, latched redirect target and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PCTL_IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule
